// File: rtl/countdown_sequencer.sv
// countdown_sequencer: input conditioning, speed-scaled ticks and SET/RUN/ALARM sequencing for a BCD countdown
module countdown_sequencer #(
  parameter int BASE_DIV   = 50_000_000,
  parameter int DB_CYC     = 1_000_000,
  parameter int REPEAT_CYC = 12_500_000
) (
  input  logic       Clk_50MHz,
  input  logic       Rst_n,
  input  logic [3:0] Sw,
  input  logic       Up,
  input  logic       Down,
  input  logic       Accel,
  input  logic       Zero,
  output logic       Tick,
  output logic       Inc,
  output logic       Dec,
  output logic [1:0] Field,
  output logic       Led,
  output logic [2:0] ALed,
  output logic [1:0] State
);
  localparam int PW = $clog2(BASE_DIV + 1);
  localparam int DW = $clog2(DB_CYC + 1);
  localparam int RW = $clog2(REPEAT_CYC + 1);
  typedef enum logic [1:0] {SET = 2'd0, RUN = 2'd1, ALARM = 2'd2} state_t;
  state_t state, state_nxt;
  logic [3:0] sw_m, sw_s;
  logic [2:0] btn_m, btn_s, db, db_q, press;
  logic [2:0] aled;
  logic [PW-1:0] presc, div_m1;
  logic [RW-1:0] rcnt;
  logic [1:0] field_c;
  logic one_held, any_press, rep, inc_req, dec_req;
  // two-flop synchronisers; buttons are active-low so they settle to released
  always_ff @(posedge Clk_50MHz or negedge Rst_n)
    if (!Rst_n) begin
      sw_m  <= '0;
      sw_s  <= '0;
      btn_m <= '1;
      btn_s <= '1;
    end else begin
      sw_m  <= Sw;
      sw_s  <= sw_m;
      btn_m <= {Accel, Down, Up};
      btn_s <= btn_m;
    end
  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [DW-1:0] cnt;
    logic lvl;
    // adopt the synced level once it has held a new value for DB_CYC cycles
    always_ff @(posedge Clk_50MHz or negedge Rst_n)
      if (!Rst_n) begin
        cnt <= '0;
        lvl <= 1'b1;
      end else if (btn_s[i] == lvl) cnt <= '0;
      else if (cnt == DW'(DB_CYC - 1)) begin
        cnt <= '0;
        lvl <= btn_s[i];
      end else cnt <= cnt + DW'(1);
    assign db[i] = lvl;
  end
  // previous debounced levels for falling-edge (press) detection
  always_ff @(posedge Clk_50MHz or negedge Rst_n)
    if (!Rst_n) db_q <= '1;
    else db_q <= db;
  assign press     = db_q & ~db;
  assign one_held  = db[0] ^ db[1];
  assign any_press = press[0] | press[1];
  assign div_m1    = aled[2] ? PW'(BASE_DIV / 4 - 1) : aled[1] ? PW'(BASE_DIV / 2 - 1) : PW'(BASE_DIV - 1);
  // speed selector rotates 1x -> 2x -> 4x on each Accel press, in every state
  always_ff @(posedge Clk_50MHz or negedge Rst_n)
    if (!Rst_n) aled <= 3'b001;
    else if (press[2]) aled <= {aled[1:0], aled[2]};
  // tick prescaler runs only in RUN and restarts on any speed change
  always_ff @(posedge Clk_50MHz or negedge Rst_n)
    if (!Rst_n) presc <= '0;
    else presc <= (state == RUN && !press[2] && presc != div_m1) ? presc + PW'(1) : '0;
  // auto-repeat timer counts while exactly one of Up/Down is held in SET
  always_ff @(posedge Clk_50MHz or negedge Rst_n)
    if (!Rst_n) rcnt <= '0;
    else rcnt <= (state == SET && one_held && !any_press && !rep) ? rcnt + RW'(1) : '0;
  // state register
  always_ff @(posedge Clk_50MHz or negedge Rst_n)
    if (!Rst_n) state <= SET;
    else state <= state_nxt;
  // next state, field decode and edit command requests
  always_comb begin
    state_nxt = state;
    field_c   = 2'd3;
    rep       = 1'b0;
    inc_req   = 1'b0;
    dec_req   = 1'b0;
    state_nxt = sw_s[0] ? SET : (state == ALARM || Zero) ? ALARM : RUN;
    field_c   = sw_s[3:1] == 3'b001 ? 2'd0 : sw_s[3:1] == 3'b010 ? 2'd1 : sw_s[3:1] == 3'b100 ? 2'd2 : 2'd3;
    rep       = state == SET && one_held && !any_press && rcnt == RW'(REPEAT_CYC - 1);
    inc_req   = (press[0] && !press[1]) || (rep && !db[0]);
    dec_req   = (press[1] && !press[0]) || (rep && !db[1]);
  end
  // registered one-cycle command outputs
  always_ff @(posedge Clk_50MHz or negedge Rst_n)
    if (!Rst_n) begin
      Tick  <= 1'b0;
      Inc   <= 1'b0;
      Dec   <= 1'b0;
      Field <= 2'd3;
    end else begin
      Tick  <= state == RUN && !sw_s[0] && !Zero && presc == div_m1;
      Inc   <= state == SET && field_c != 2'd3 && inc_req;
      Dec   <= state == SET && field_c != 2'd3 && dec_req;
      Field <= field_c;
    end
  assign Led   = state == ALARM;
  assign ALed  = aled;
  assign State = state;
endmodule

// File: tb/tb_countdown_sequencer.sv
// tb_countdown_sequencer: table, corner-case and random checks against a history-based reference model
module tb_countdown_sequencer;
  localparam int BD = 8;
  localparam int DB = 4;
  localparam int R  = 16;
  typedef struct {
    logic up, dn, ac;
    logic [3:0] sw;
    logic z;
    int n, ticks, incs, decs;
    logic [1:0] st;
    logic led;
    logic [2:0] aled;
    logic [1:0] fld;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n, up, down, accel, zero;
  logic [3:0] sw;
  logic tick, inc, dec, led;
  logic [1:0] field, state;
  logic [2:0] aled;
  int n_chk = 0, n_pass = 0;
  logic [2:0] h_btn [8];
  logic [3:0] h_sw [8];
  logic [2:0] m_db, m_dbp, m_aled;
  logic [1:0] m_field;
  logic m_tick, m_inc, m_dec;
  int m_state, m_phase, m_hold;
  vec_t tbl [18];
  always #5 clk = ~clk;
  countdown_sequencer #(.BASE_DIV(BD), .DB_CYC(DB), .REPEAT_CYC(R)) dut (
    .Clk_50MHz(clk), .Rst_n(rst_n), .Sw(sw), .Up(up), .Down(down), .Accel(accel), .Zero(zero),
    .Tick(tick), .Inc(inc), .Dec(dec), .Field(field), .Led(led), .ALed(aled), .State(state)
  );
  function automatic logic [31:0] dut_pack();
    return 32'({state, led, aled, field, tick, inc, dec});
  endfunction
  function automatic logic [31:0] mdl_pack();
    return 32'({m_state[1:0], m_state == 2, m_aled, m_field, m_tick, m_inc, m_dec});
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    else n_pass++;
  endtask
  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      h_btn[k] = 3'b111;
      h_sw[k]  = 4'b0000;
    end
    m_db = 3'b111; m_dbp = 3'b111; m_aled = 3'b001; m_field = 2'd3;
    m_tick = 0; m_inc = 0; m_dec = 0; m_state = 0; m_phase = 0; m_hold = 0;
  endtask
  // reference: synced value = raw from two edges ago; a button's level follows the raw value once
  // it has been the same over the last DB synced samples; everything else follows the written rules
  task automatic model_step(input logic u, input logic d, input logic a, input logic [3:0] s, input logic z);
    logic [1:0] fld;
    logic [2:0] nd;
    logic pu, pd, pa, one, cond, rep, sw0, same;
    int div;
    for (int k = 7; k > 0; k--) begin
      h_btn[k] = h_btn[k-1];
      h_sw[k]  = h_sw[k-1];
    end
    h_btn[0] = {a, d, u};
    h_sw[0]  = s;
    sw0 = h_sw[2][0];
    case (h_sw[2][3:1])
      3'b001: fld = 2'd0;
      3'b010: fld = 2'd1;
      3'b100: fld = 2'd2;
      default: fld = 2'd3;
    endcase
    pu = m_dbp[0] && !m_db[0];
    pd = m_dbp[1] && !m_db[1];
    pa = m_dbp[2] && !m_db[2];
    one = m_db[0] != m_db[1];
    div = m_aled == 3'b001 ? BD : m_aled == 3'b010 ? BD / 2 : BD / 4;
    cond = m_state == 0 && one && !pu && !pd;
    rep = cond && (m_hold % R == R - 1);
    m_hold = cond ? m_hold + 1 : 0;
    m_inc = m_state == 0 && fld != 2'd3 && ((pu && !pd) || (rep && !m_db[0]));
    m_dec = m_state == 0 && fld != 2'd3 && ((pd && !pu) || (rep && !m_db[1]));
    m_tick = m_state == 1 && !sw0 && !z && (m_phase % div == div - 1);
    m_phase = (m_state == 1 && !pa) ? m_phase + 1 : 0;
    m_field = fld;
    if (pa) m_aled = {m_aled[1:0], m_aled[2]};
    m_state = sw0 ? 0 : (m_state == 2 || z) ? 2 : 1;
    for (int b = 0; b < 3; b++) begin
      same = 1'b1;
      for (int k = 3; k <= DB + 1; k++) if (h_btn[k][b] != h_btn[2][b]) same = 1'b0;
      nd[b] = same ? h_btn[2][b] : m_db[b];
    end
    m_dbp = m_db;
    m_db = nd;
  endtask
  task automatic step(input logic u, input logic d, input logic a, input logic [3:0] s, input logic z);
    up = u; down = d; accel = a; sw = s; zero = z;
    @(posedge clk);
    model_step(u, d, a, s, z);
    #1;
    check("cycle", dut_pack(), mdl_pack());
  endtask
  initial begin
    int t, ic, dc, fb, k;
    logic ru, rd, ra, rz;
    logic [3:0] rs;
    tbl = '{
      '{1, 1, 1, 4'b0000, 0, 35, 4, 0, 0, 2'd1, 0, 3'b001, 2'd3},
      '{1, 1, 1, 4'b0000, 1, 3, 0, 0, 0, 2'd2, 1, 3'b001, 2'd3},
      '{1, 1, 1, 4'b0000, 0, 10, 0, 0, 0, 2'd2, 1, 3'b001, 2'd3},
      '{1, 1, 1, 4'b0001, 0, 5, 0, 0, 0, 2'd0, 0, 3'b001, 2'd3},
      '{0, 1, 1, 4'b0101, 0, 40, 0, 3, 0, 2'd0, 0, 3'b001, 2'd1},
      '{1, 1, 1, 4'b0101, 0, 20, 0, 0, 0, 2'd0, 0, 3'b001, 2'd1},
      '{1, 0, 1, 4'b0101, 0, 12, 0, 0, 1, 2'd0, 0, 3'b001, 2'd1},
      '{1, 1, 1, 4'b0101, 0, 20, 0, 0, 0, 2'd0, 0, 3'b001, 2'd1},
      '{0, 0, 1, 4'b1001, 0, 30, 0, 0, 0, 2'd0, 0, 3'b001, 2'd2},
      '{1, 1, 1, 4'b0111, 0, 20, 0, 0, 0, 2'd0, 0, 3'b001, 2'd3},
      '{1, 0, 1, 4'b0111, 0, 12, 0, 0, 0, 2'd0, 0, 3'b001, 2'd3},
      '{1, 1, 1, 4'b0100, 0, 20, 2, 0, 0, 2'd1, 0, 3'b001, 2'd3},
      '{1, 1, 0, 4'b0100, 0, 10, 1, 0, 0, 2'd1, 0, 3'b010, 2'd3},
      '{1, 1, 1, 4'b0100, 0, 20, 5, 0, 0, 2'd1, 0, 3'b010, 2'd3},
      '{1, 1, 0, 4'b0100, 0, 10, 3, 0, 0, 2'd1, 0, 3'b100, 2'd3},
      '{1, 1, 1, 4'b0100, 0, 12, 6, 0, 0, 2'd1, 0, 3'b100, 2'd3},
      '{1, 1, 0, 4'b0100, 0, 10, 4, 0, 0, 2'd1, 0, 3'b001, 2'd3},
      '{1, 1, 1, 4'b0100, 0, 20, 2, 0, 0, 2'd1, 0, 3'b001, 2'd3}
    };
    rst_n = 0; up = 1; down = 1; accel = 1; sw = 4'b0000; zero = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    check("reset", dut_pack(), 32'({2'd0, 1'b0, 3'b001, 2'd3, 3'b000}));
    for (int i = 0; i < 18; i++) begin
      t = 0; ic = 0; dc = 0; fb = 0;
      for (int c = 0; c < tbl[i].n; c++) begin
        step(tbl[i].up, tbl[i].dn, tbl[i].ac, tbl[i].sw, tbl[i].z);
        if (tick) t++;
        if (inc) ic++;
        if (dec) dc++;
        if ((inc || dec) && field != tbl[i].fld) fb++;
      end
      check($sformatf("v%0d_ticks", i), t, tbl[i].ticks);
      check($sformatf("v%0d_incs", i), ic, tbl[i].incs);
      check($sformatf("v%0d_decs", i), dc, tbl[i].decs);
      check($sformatf("v%0d_field", i), fb, 0);
      check($sformatf("v%0d_state", i), 32'(state), 32'(tbl[i].st));
      check($sformatf("v%0d_led", i), 32'(led), 32'(tbl[i].led));
      check($sformatf("v%0d_aled", i), 32'(aled), 32'(tbl[i].aled));
    end
    step(1, 1, 1, 4'b0100, 1);
    check("alarm_state", 32'(state), 32'd2);
    check("alarm_led", 32'(led), 32'd1);
    k = 0;
    do begin
      step(1, 1, 1, 4'b0101, 0);
      k++;
    end while (state != 2'd0 && k < 6);
    check("alarm_exit_cycles", k, 3);
    check("alarm_exit_led", 32'(led), 32'd0);
    k = 0;
    do begin
      step(1, 1, 1, 4'b0000, 0);
      k++;
    end while (state != 2'd1 && k < 6);
    check("run_entry_cycles", k, 3);
    repeat (10) step(1, 1, 0, 4'b0000, 0);
    repeat (10) step(1, 1, 1, 4'b0000, 0);
    check("speed_2x", 32'(aled), 32'b010);
    k = 0;
    do begin
      step(1, 1, 1, 4'b0000, 0);
      k++;
    end while (!tick && k < 10);
    check("tick_wait", 32'(tick), 32'd1);
    repeat (2) step(1, 1, 1, 4'b0000, 0);
    #2 rst_n = 0;
    #1 check("async_reset", dut_pack(), 32'({2'd0, 1'b0, 3'b001, 2'd3, 3'b000}));
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    k = 0;
    do begin
      step(1, 1, 1, 4'b0000, 0);
      k++;
    end while (!tick && k < 20);
    check("first_tick_after_reset", k, 9);
    ru = 1; rd = 1; ra = 1; rs = 4'b0000; rz = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) ru = ~ru;
      if ($urandom_range(0, 19) == 0) rd = ~rd;
      if ($urandom_range(0, 29) == 0) ra = ~ra;
      if ($urandom_range(0, 79) == 0) rs = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) rz = ~rz;
      step(ru, rd, ra, rs, rz);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
